// File: rtl/maze_link_pipe.sv
// maze_link_pipe: point-to-point MAZE link built from DEPTH bubble-collapsing
// register stages, carrying one valid/ready packet stream at full throughput.
// Also provides a drain mode, a synchronous flush with drop accounting, live
// occupancy, and saturating in/out/drop packet counters.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   valid_i/ready_o/payload_i   upstream packet handshake
//   valid_o/ready_i/payload_o   downstream packet handshake (last stage)
//   link_en               1: accept new packets, 0: drain only
//   flush                 synchronous clear of all stages (contents dropped)
//   occupancy, empty      number of occupied stages / no stage occupied
//   in_cnt/out_cnt/drop_cnt     saturating packet statistics
//   clr_cnt               synchronous clear of the statistics counters
module maze_link_pipe #(
  parameter  int unsigned PYLD_W = 23,
  parameter  int unsigned DEPTH  = 1,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [PYLD_W-1:0] payload_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [PYLD_W-1:0] payload_o,
  input  logic              link_en,
  input  logic              flush,
  output logic [OCC_W-1:0]  occupancy,
  output logic              empty,
  output logic [CNT_W-1:0]  in_cnt,
  output logic [CNT_W-1:0]  out_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  input  logic              clr_cnt
);

  localparam int unsigned SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Reject illegal stage counts at elaboration time.
  generate
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
      $error("maze_link_pipe: DEPTH must be in 1..8");
    end
  endgenerate

  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  mv;
  logic [PYLD_W-1:0] data [DEPTH];
  logic              accept;
  logic              deliver;
  logic [OCC_W-1:0]  occ_c;
  logic [SUM_W-1:0]  drop_sum_c;

  // Stage advance: a stage moves when it holds a packet and the next slot is
  // free or itself moving; the ripple from the tail collapses bubbles.
  always_comb begin
    mv = '0;
    mv[DEPTH-1] = v[DEPTH-1] & ready_i;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      mv[k] = v[k] & (~v[k+1] | mv[k+1]);
    end
  end

  // Reset gating keeps the link closed while rst_n is asserted.
  assign ready_o = rst_n & link_en & ~flush & (~v[0] | mv[0]);
  assign accept  = valid_i & ready_o;
  assign deliver = mv[DEPTH-1] & ~flush;

  // Stage valids and payloads; empty stages keep their stale payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data[k] <= '0;
      end
    end else begin
      if (flush) begin
        v <= '0;
      end else begin
        v[0] <= (v[0] & ~mv[0]) | accept;
        for (int k = 1; k < int'(DEPTH); k++) begin
          v[k] <= (v[k] & ~mv[k]) | mv[k-1];
        end
      end
      if (accept) begin
        data[0] <= payload_i;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (mv[k-1]) begin
          data[k] <= data[k-1];
        end
      end
    end
  end

  assign valid_o   = v[DEPTH-1];
  assign payload_o = data[DEPTH-1];

  // Occupancy is the population count of the stage valids.
  always_comb begin
    occ_c = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      occ_c = occ_c + OCC_W'(v[k]);
    end
  end

  assign occupancy = occ_c;
  assign empty     = ~|v;

  assign drop_sum_c = SUM_W'(drop_cnt) + SUM_W'(occ_c);

  // Statistics counters: clear wins over increment, all saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else if (clr_cnt) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept && in_cnt != CNT_MAX) begin
        in_cnt <= in_cnt + CNT_W'(1);
      end
      if (deliver && out_cnt != CNT_MAX) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end
      if (flush) begin
        if (drop_sum_c > SUM_W'(CNT_MAX)) begin
          drop_cnt <= CNT_MAX;
        end else begin
          drop_cnt <= CNT_W'(drop_sum_c);
        end
      end
    end
  end

endmodule
